// File: rtl/coin_pulser.sv
// coin_pulser: turns a requested count into a pulse train followed by an idle commit gap.
// Optional abort support is enabled by defining COIN_PULSER_ABORT_EN.
module coin_pulser #(
  parameter int PULSE_HIGH = 2,
  parameter int PULSE_LOW  = 2,
  parameter int COMMIT_GAP = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] count_in,
  input  logic       valid,
  output logic       ready,
  input  logic       abort,
  output logic       pulse_out,
  output logic [5:0] remaining,
  output logic       done,
  output logic       aborted
);
  localparam int MX = (PULSE_HIGH > PULSE_LOW ? PULSE_HIGH : PULSE_LOW) > COMMIT_GAP ?
                      (PULSE_HIGH > PULSE_LOW ? PULSE_HIGH : PULSE_LOW) : COMMIT_GAP;
  localparam int W = $clog2(MX + 1);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, COMMIT} state_t;
  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [5:0]     rem_q, rem_d;
  logic           ab_q, ab_d, pulse_q, done_q, aborted_q;
  logic           last, abort_req;
`ifdef COIN_PULSER_ABORT_EN
  assign abort_req = abort && (state_q == HIGH || state_q == LOW);
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_req = 1'b0;
`endif
  assign last = cnt_q == '0;
  always_comb begin
    state_d = state_q;
    cnt_d   = last ? cnt_q : cnt_q - 1'b1;
    rem_d   = rem_q;
    ab_d    = ab_q;
    unique case (state_q)
      IDLE: if (valid && count_in != 6'd0) begin
        state_d = HIGH;
        cnt_d   = W'(PULSE_HIGH - 1);
        rem_d   = count_in - 6'd1;
        ab_d    = 1'b0;
      end
      HIGH: if (abort_req) begin
        state_d = COMMIT;
        cnt_d   = W'(COMMIT_GAP - 1);
        ab_d    = 1'b1;
      end else if (last) begin
        state_d = rem_q != 6'd0 ? LOW : COMMIT;
        cnt_d   = rem_q != 6'd0 ? W'(PULSE_LOW - 1) : W'(COMMIT_GAP - 1);
      end
      LOW: if (abort_req) begin
        state_d = COMMIT;
        cnt_d   = W'(COMMIT_GAP - 1);
        ab_d    = 1'b1;
      end else if (last) begin
        state_d = HIGH;
        cnt_d   = W'(PULSE_HIGH - 1);
        rem_d   = rem_q - 6'd1;
      end
      COMMIT: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      ab_q      <= 1'b0;
      pulse_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      ab_q      <= ab_d;
      pulse_q   <= state_d == HIGH;
      done_q    <= state_q == COMMIT && last && !ab_q;
      aborted_q <= state_q == COMMIT && last && ab_q;
    end
  end
  assign ready     = state_q == IDLE;
  assign pulse_out = pulse_q;
  assign remaining = rem_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
endmodule
